// File: rtl/cp0_pkg.sv
// Shared CPU constants for the coprocessor-0 block: register numbers,
// field bit positions, exception codes and the default exception entry address.
package cp0_pkg;

   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;
   localparam logic [4:0] CP0_PRID  = 5'd15;

   localparam int SR_IE_BIT       = 0;
   localparam int SR_EXL_BIT      = 1;
   localparam int SR_IM_LSB       = 10;
   localparam int CAUSE_EXC_LSB   = 2;
   localparam int CAUSE_IP_LSB    = 10;
   localparam int CAUSE_BD_BIT    = 31;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam logic [31:0] DEF_PRID_VALUE = 32'h0000_2023;
   localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;

   // Word-align an address by clearing its two low bits.
   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId, interrupt and exception detection in M,
// and the flush-and-redirect request consumed directly by the pipeline registers.
module cp0_unit
   import cp0_pkg::*;
#(
   parameter logic [31:0] PRID_VALUE = DEF_PRID_VALUE,
   parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        en,
   input  logic [4:0]  addr,
   input  logic [31:0] wdata,
   input  logic [31:0] m_pc,
   input  logic [4:0]  m_excCode,
   input  logic        m_delaySlot,
   input  logic        m_eret,
   input  logic [5:0]  hwint,
   output logic [31:0] rdata,
   output logic [31:0] epc_out,
   output logic        req,
   output logic [31:0] handler_pc
);

   logic [5:0]  sr_im;
   logic        sr_exl;
   logic        sr_ie;
   logic        cause_bd;
   logic [5:0]  cause_ip;
   logic [4:0]  cause_exc;
   logic [31:0] epc;

   logic        int_req;
   logic        exc_req;
   logic [31:0] sr_word;
   logic [31:0] cause_word;

   assign int_req    = (|(hwint & sr_im)) & sr_ie & ~sr_exl;
   assign exc_req    = (m_excCode != 5'd0) & ~sr_exl;
   assign req        = int_req | exc_req;
   assign handler_pc = HANDLER_PC;
   assign epc_out    = epc;

   always_comb begin
      sr_word = '0;
      sr_word[SR_IM_LSB +: 6] = sr_im;
      sr_word[SR_EXL_BIT]     = sr_exl;
      sr_word[SR_IE_BIT]      = sr_ie;

      cause_word = '0;
      cause_word[CAUSE_BD_BIT]       = cause_bd;
      cause_word[CAUSE_IP_LSB +: 6]  = cause_ip;
      cause_word[CAUSE_EXC_LSB +: 5] = cause_exc;

      case (addr)
         CP0_SR:    rdata = sr_word;
         CP0_CAUSE: rdata = cause_word;
         CP0_EPC:   rdata = epc;
         CP0_PRID:  rdata = PRID_VALUE;
         default:   rdata = '0;
      endcase
   end

   // Exception entry outranks mtc0 and eret; eret is applied after mtc0 in the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sr_im     <= '0;
         sr_exl    <= 1'b0;
         sr_ie     <= 1'b0;
         cause_bd  <= 1'b0;
         cause_ip  <= '0;
         cause_exc <= '0;
         epc       <= '0;
      end else begin
         cause_ip <= hwint;
         if (req) begin
            sr_exl    <= 1'b1;
            cause_bd  <= m_delaySlot;
            cause_exc <= int_req ? EXC_INT : m_excCode;
            epc       <= word_align(m_delaySlot ? (m_pc - 32'd4) : m_pc);
         end else begin
            if (en && addr == CP0_SR) begin
               sr_im  <= wdata[SR_IM_LSB +: 6];
               sr_exl <= wdata[SR_EXL_BIT];
               sr_ie  <= wdata[SR_IE_BIT];
            end else if (en && addr == CP0_EPC) begin
               epc <= word_align(wdata);
            end
            if (m_eret) begin
               sr_exl <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: a vector table for single-cycle behaviour plus
// hand-written sequences for reset, mid-handler reset and same-cycle read/write.
module tb_cp0_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        en;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic [31:0] m_pc;
   logic [4:0]  m_excCode;
   logic        m_delaySlot;
   logic        m_eret;
   logic [5:0]  hwint;
   logic [31:0] rdata;
   logic [31:0] epc_out;
   logic        req;
   logic [31:0] handler_pc;

   int n_checks = 0;
   int n_errors = 0;

   cp0_unit dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .en          (en),
      .addr        (addr),
      .wdata       (wdata),
      .m_pc        (m_pc),
      .m_excCode   (m_excCode),
      .m_delaySlot (m_delaySlot),
      .m_eret      (m_eret),
      .hwint       (hwint),
      .rdata       (rdata),
      .epc_out     (epc_out),
      .req         (req),
      .handler_pc  (handler_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [31:0] pc;
      logic [4:0]  exc;
      logic        ds;
      logic        eret;
      logic [5:0]  hw;
      logic        exp_req;
      logic [4:0]  chk;
      logic [31:0] exp_rd;
      logic [31:0] exp_epc;
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      en = 1'b0; addr = 5'd0; wdata = '0; m_pc = '0;
      m_excCode = '0; m_delaySlot = 1'b0; m_eret = 1'b0; hwint = '0;
   endtask

   initial begin
      //          en addr wdata          pc          exc ds er hw  req chk exp_rd          exp_epc
      vecs[0]  = '{0, 0,  32'h0,         32'h3010,   10, 0, 0, 0,  1,  14, 32'h0000_3010,  32'h0000_3010};
      vecs[1]  = '{0, 0,  32'h0,         32'h0,      10, 0, 0, 0,  0,  13, 32'h0000_0028,  32'h0000_3010};
      vecs[2]  = '{0, 0,  32'h0,         32'h0,      0,  0, 0, 0,  0,  12, 32'h0000_0002,  32'h0000_3010};
      vecs[3]  = '{0, 0,  32'h0,         32'h0,      0,  0, 1, 0,  0,  12, 32'h0000_0000,  32'h0000_3010};
      vecs[4]  = '{0, 0,  32'h0,         32'h3024,   12, 1, 0, 0,  1,  13, 32'h8000_0030,  32'h0000_3020};
      vecs[5]  = '{0, 0,  32'h0,         32'h0,      0,  0, 1, 0,  0,  12, 32'h0000_0000,  32'h0000_3020};
      vecs[6]  = '{1, 12, 32'h401,       32'h0,      0,  0, 0, 0,  0,  12, 32'h0000_0401,  32'h0000_3020};
      vecs[7]  = '{0, 0,  32'h0,         32'h3040,   0,  0, 0, 1,  1,  13, 32'h0000_0400,  32'h0000_3040};
      vecs[8]  = '{0, 0,  32'h0,         32'h0,      0,  0, 1, 0,  0,  12, 32'h0000_0401,  32'h0000_3040};
      vecs[9]  = '{1, 12, 32'h400,       32'h0,      0,  0, 0, 0,  0,  12, 32'h0000_0400,  32'h0000_3040};
      vecs[10] = '{0, 0,  32'h0,         32'h0,      0,  0, 0, 1,  0,  13, 32'h0000_0400,  32'h0000_3040};
      vecs[11] = '{1, 13, 32'hFFFF_FFFF, 32'h0,      0,  0, 0, 0,  0,  13, 32'h0000_0000,  32'h0000_3040};
      vecs[12] = '{1, 15, 32'h0,         32'h0,      0,  0, 0, 0,  0,  15, 32'h0000_2023,  32'h0000_3040};
      vecs[13] = '{1, 14, 32'h1234_5677, 32'h0,      0,  0, 0, 0,  0,  14, 32'h1234_5674,  32'h1234_5674};
      vecs[14] = '{1, 14, 32'h5000,      32'h3100,   4,  0, 0, 0,  1,  14, 32'h0000_3100,  32'h0000_3100};
      vecs[15] = '{0, 0,  32'h0,         32'h0,      0,  0, 1, 0,  0,  12, 32'h0000_0400,  32'h0000_3100};
      vecs[16] = '{1, 12, 32'h401,       32'h0,      0,  0, 0, 0,  0,  12, 32'h0000_0401,  32'h0000_3100};
      vecs[17] = '{0, 0,  32'h0,         32'h3200,   5,  0, 0, 1,  1,  13, 32'h0000_0400,  32'h0000_3200};

      // Reset held: everything reads zero, no request.
      idle_inputs();
      reset_n = 1'b0;
      #2;
      check("reset_req", {31'd0, req}, 32'd0);
      for (int a = 12; a <= 14; a++) begin
         addr = 5'(a);
         #1;
         check($sformatf("reset_rd%0d", a), rdata, 32'd0);
      end
      check("reset_epc", epc_out, 32'd0);
      check("handler_pc", handler_pc, 32'h0000_4180);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      addr = 5'd12;
      #1;
      check("post_reset_sr", rdata, 32'd0);
      check("post_reset_req", {31'd0, req}, 32'd0);
      check("post_reset_epc", epc_out, 32'd0);

      // Table-driven single-cycle vectors.
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         en = vecs[i].en; addr = vecs[i].addr; wdata = vecs[i].wdata;
         m_pc = vecs[i].pc; m_excCode = vecs[i].exc; m_delaySlot = vecs[i].ds;
         m_eret = vecs[i].eret; hwint = vecs[i].hw;
         #1;
         check($sformatf("v%0d_req", i), {31'd0, req}, {31'd0, vecs[i].exp_req});
         @(posedge clk);
         #1;
         en = 1'b0; m_excCode = '0; m_eret = 1'b0; m_delaySlot = 1'b0;
         addr = vecs[i].chk;
         #1;
         check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rd);
         check($sformatf("v%0d_epc", i), epc_out, vecs[i].exp_epc);
      end

      // Asynchronous reset in the middle of a handler (EXL=1 from the last vector).
      @(negedge clk);
      idle_inputs();
      addr = 5'd12;
      #1;
      check("pre_async_sr", rdata, 32'h0000_0403);
      reset_n = 1'b0;
      #1;
      check("async_sr", rdata, 32'd0);
      addr = 5'd14;
      #1;
      check("async_epc", epc_out, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      m_excCode = 5'd10; m_pc = 32'h3300;
      #1;
      check("rearm_req", {31'd0, req}, 32'd1);
      @(posedge clk);
      #1;
      idle_inputs();
      #1;
      check("rearm_epc", epc_out, 32'h0000_3300);

      // Same-cycle mtc0/mfc0 to EPC returns the old value; new value only after the edge.
      @(negedge clk);
      en = 1'b1; addr = 5'd14; wdata = 32'h0000_8888;
      #1;
      check("rw_old_rdata", rdata, 32'h0000_3300);
      check("rw_old_epc", epc_out, 32'h0000_3300);
      @(posedge clk);
      #1;
      en = 1'b0;
      #1;
      check("rw_new_epc", epc_out, 32'h0000_8888);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
